fht_sequencer: RTL and testbench

FHT_SEQUENCER -- requirements
Module: fht_sequencer

---
 rtl/fht_sequencer_if.sv | 43 ++++
 rtl/fht_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fht_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_sequencer_if.sv
// Control and address bundle of the FHT address sequencer.
// master: host side (start/abort/length); slave: the sequencer.
interface fht_sequencer_if #(
    parameter int N_LOG2 = 10
);
    localparam int A_BIT = N_LOG2 - 2;

    logic             iSTART;
    logic             iABORT;
    logic [3:0]       iLOG2_LEN;
    logic [A_BIT-1:0] oADDR_RD;
    logic [A_BIT-1:0] oADDR_RD_ALT;
    logic [A_BIT-1:0] oADDR_WR;
    logic [A_BIT-1:0] oADDR_WR_ALT;
    logic [A_BIT-1:0] oADDR_COEF;
    logic [A_BIT-1:0] oSECTOR;
    logic             o2ND_PART_SUBSEC;
    logic             oST_ZERO;
    logic             oST_LAST;
    logic [3:0]       oSTAGE;
    logic             oWE_A;
    logic             oWE_B;
    logic             oSOURCE_DATA;
    logic             oBUSY;
    logic             oDONE;
    logic             oERR;

    modport master (
        output iSTART, iABORT, iLOG2_LEN,
        input  oADDR_RD, oADDR_RD_ALT, oADDR_WR, oADDR_WR_ALT,
        input  oADDR_COEF, oSECTOR, o2ND_PART_SUBSEC,
        input  oST_ZERO, oST_LAST, oSTAGE, oWE_A, oWE_B,
        input  oSOURCE_DATA, oBUSY, oDONE, oERR
    );

    modport slave (
        input  iSTART, iABORT, iLOG2_LEN,
        output oADDR_RD, oADDR_RD_ALT, oADDR_WR, oADDR_WR_ALT,
        output oADDR_COEF, oSECTOR, o2ND_PART_SUBSEC,
        output oST_ZERO, oST_LAST, oSTAGE, oWE_A, oWE_B,
        output oSOURCE_DATA, oBUSY, oDONE, oERR
    );
endinterface

// File: rtl/fht_sequencer.sv
// Address/stage sequencer for an in-place 4-bank FHT.
// Ports: iCLK, iRESET (sync, active-low), bus (slave modport).
module fht_sequencer #(
    parameter int N_LOG2   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic           iCLK,
    input  logic           iRESET,
    fht_sequencer_if.slave bus
);
    localparam int A_BIT = N_LOG2 - 2;
    localparam logic [3:0] LMAX = 4'(N_LOG2);
    localparam logic [3:0] DC_LAST = 4'(PIPE_LAT);
    localparam logic [A_BIT-1:0] ONE = A_BIT'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, nxt_state;
    logic [3:0]       s, nxt_s;
    logic [3:0]       len, nxt_len;
    logic [3:0]       dc, nxt_dc;
    logic [A_BIT-1:0] t, nxt_t;
    logic [A_BIT-1:0] d_last;
    logic             err_n;

    logic [3:0]       base_lg, shift, lg;
    logic [A_BIT-1:0] mask, u, half;
    logic [A_BIT-1:0] sec_n, alt_n, coef_n;
    logic             sec2_n, run_n, act_n;

    logic [A_BIT-1:0] rd_q, alt_q, sec_q, coef_q;
    logic             sec2_q, zero_q, last_q, src_q;
    logic             busy_q, done_q, err_q;

    logic             v_pipe   [PIPE_LAT];
    logic [A_BIT-1:0] wr_pipe  [PIPE_LAT];
    logic [A_BIT-1:0] wra_pipe [PIPE_LAT];

    // last read index of a stage: 2^(L-2)-1, wraps cleanly at L=N_LOG2
    assign d_last = (ONE << (len - 4'd2)) - ONE;

    always_comb begin
        nxt_state = state;
        nxt_s     = s;
        nxt_t     = t;
        nxt_dc    = dc;
        nxt_len   = len;
        err_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.iSTART) begin
                    if (bus.iLOG2_LEN >= 4'd4 &&
                        bus.iLOG2_LEN <= LMAX) begin
                        nxt_state = RUN;
                        nxt_len   = bus.iLOG2_LEN;
                        nxt_s     = 4'd0;
                        nxt_t     = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (t == d_last) begin
                    nxt_state = DRAIN;
                    nxt_t     = '0;
                    nxt_dc    = 4'd0;
                end else begin
                    nxt_t = t + ONE;
                end
            end
            DRAIN: begin
                if (dc == DC_LAST) begin
                    if (s == len - 4'd1) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_state = RUN;
                        nxt_s     = s + 4'd1;
                    end
                end else begin
                    nxt_dc = dc + 4'd1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
                nxt_s     = 4'd0;
            end
        endcase
    end

    // Sector geometry of the next read, as log2 of the sector size:
    // full depth on stages 0/1, then halving, never below 2 words.
    always_comb begin
        base_lg = nxt_len - 4'd2;
        shift   = (nxt_s > 4'd1) ? nxt_s - 4'd1 : 4'd0;
        lg      = (shift >= base_lg) ? 4'd1 : base_lg - shift;
        mask    = (ONE << lg) - ONE;
        half    = ONE << (lg - 4'd1);
        u       = nxt_t & mask;
        run_n   = (nxt_state == RUN);
        act_n   = run_n || (nxt_state == DRAIN);
        sec_n   = run_n ? (nxt_t >> lg) : '0;
        sec2_n  = run_n && (nxt_s != 4'd0) && (u >= half);
        if (!run_n)
            alt_n = '0;
        else if (nxt_s == 4'd0)
            alt_n = nxt_t;
        else
            alt_n = (nxt_t & ~mask) | ((~u + ONE) & mask);
    end

    // Coefficient ROM is sized for the longest transform, so the
    // reverse always spans the full bank address width.
    always_comb begin
        coef_n = '0;
        for (int i = 0; i < A_BIT; i++)
            coef_n[i] = sec_q[A_BIT-1-i];
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET || bus.iABORT) begin
            state  <= IDLE;
            s      <= '0;
            t      <= '0;
            dc     <= '0;
            len    <= '0;
            rd_q   <= '0;
            alt_q  <= '0;
            sec_q  <= '0;
            coef_q <= '0;
            sec2_q <= 1'b0;
            zero_q <= 1'b0;
            last_q <= 1'b0;
            src_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                v_pipe[i]   <= 1'b0;
                wr_pipe[i]  <= '0;
                wra_pipe[i] <= '0;
            end
        end else begin
            state  <= nxt_state;
            s      <= nxt_s;
            t      <= nxt_t;
            dc     <= nxt_dc;
            len    <= nxt_len;
            rd_q   <= run_n ? nxt_t : '0;
            alt_q  <= alt_n;
            sec_q  <= sec_n;
            coef_q <= coef_n;
            sec2_q <= sec2_n;
            zero_q <= act_n && (nxt_s == 4'd0);
            last_q <= act_n && (nxt_s == nxt_len - 4'd1);
            src_q  <= (nxt_state != IDLE) && nxt_s[0];
            busy_q <= (nxt_state != IDLE);
            done_q <= (nxt_state == DONE);
            err_q  <= err_n;
            v_pipe[0]   <= (state == RUN);
            wr_pipe[0]  <= rd_q;
            wra_pipe[0] <= alt_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                v_pipe[i]   <= v_pipe[i-1];
                wr_pipe[i]  <= wr_pipe[i-1];
                wra_pipe[i] <= wra_pipe[i-1];
            end
        end
    end

    // Drain is longer than the pipe, so s still names the
    // stage that owns the write leaving the pipe.
    assign bus.oWE_A = v_pipe[PIPE_LAT-1] & s[0];
    assign bus.oWE_B = v_pipe[PIPE_LAT-1] & ~s[0];

    assign bus.oADDR_RD         = rd_q;
    assign bus.oADDR_RD_ALT     = alt_q;
    assign bus.oADDR_WR         = wr_pipe[PIPE_LAT-1];
    assign bus.oADDR_WR_ALT     = wra_pipe[PIPE_LAT-1];
    assign bus.oADDR_COEF       = coef_q;
    assign bus.oSECTOR          = sec_q;
    assign bus.o2ND_PART_SUBSEC = sec2_q;
    assign bus.oST_ZERO         = zero_q;
    assign bus.oST_LAST         = last_q;
    assign bus.oSTAGE           = s;
    assign bus.oSOURCE_DATA     = src_q;
    assign bus.oBUSY            = busy_q;
    assign bus.oDONE            = done_q;
    assign bus.oERR             = err_q;
endmodule

// File: tb/tb_fht_sequencer.sv
// Scoreboard bench for fht_sequencer (PIPE_LAT 2 and 5 instances).
// Model lists every expected read/write/done/err event by cycle.
module tb_fht_sequencer;
    localparam int N_LOG2 = 10;
    localparam int A_BIT  = N_LOG2 - 2;
    localparam int P0     = 2;
    localparam int P1     = 5;

    typedef struct {
        int cyc; int s; int l; int rd; int alt;
        int sec; int sec2; int coef;
    } rd_e;
    typedef struct { int cyc; int wr; int alt; int we_a; } wr_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   clr5 = -1;

    rd_e rq[$];
    wr_e wq[$];
    int  dq[$];
    int  dq5[$];
    int  eq[$];
    int  h_rd[$];
    int  h_ra[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fht_sequencer_if #(.N_LOG2(N_LOG2)) bus ();
    fht_sequencer_if #(.N_LOG2(N_LOG2)) bus5 ();

    assign bus5.iSTART    = bus.iSTART;
    assign bus5.iABORT    = bus.iABORT;
    assign bus5.iLOG2_LEN = bus.iLOG2_LEN;

    fht_sequencer #(.N_LOG2(N_LOG2), .PIPE_LAT(P0)) dut (
        .iCLK(clk), .iRESET(rst_n), .bus(bus.slave)
    );
    fht_sequencer #(.N_LOG2(N_LOG2), .PIPE_LAT(P1)) dut5 (
        .iCLK(clk), .iRESET(rst_n), .bus(bus5.slave)
    );

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     n, cyc, act, exp);
        end
    endfunction

    function automatic void fail(string n);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", n, cyc);
    endfunction

    function automatic int mdiv(int l, int s);
        int d;
        d = 1 << (l - 2);
        if (s <= 1) return d;
        d = d >> (s - 1);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int brev(int x);
        int r = 0;
        for (int i = 0; i < A_BIT; i++)
            if ((x >> i) & 1) r |= 1 << (A_BIT - 1 - i);
        return r;
    endfunction

    // Expected events for a legal start issued in cycle k.
    function automatic void push_xfer(int k, int l);
        int d, per, dv, c, u;
        rd_e e;
        wr_e w;
        d   = 1 << (l - 2);
        per = d + P0 + 1;
        for (int s = 0; s < l; s++) begin
            dv = mdiv(l, s);
            for (int t = 0; t < d; t++) begin
                c = k + 1 + s * per + t;
                u = t % dv;
                e.cyc = c; e.s = s; e.l = l; e.rd = t;
                e.alt = (s == 0) ? t : (t - u) + ((dv - u) % dv);
                e.sec = t / dv;
                e.sec2 = (s != 0 && u >= dv / 2) ? 1 : 0;
                e.coef = (s == 0 || t == 0) ? 0 : brev((t - 1) / dv);
                rq.push_back(e);
                w.cyc = c + P0; w.wr = t; w.alt = e.alt;
                w.we_a = s % 2;
                wq.push_back(w);
            end
        end
        dq.push_back(k + 1 + l * per);
        dq5.push_back(k + 1 + l * (d + P1 + 1));
    endfunction

    // Abort/reset seen at the edge ending cycle a: nothing after it.
    function automatic void purge(int a);
        for (int i = rq.size() - 1; i >= 0; i--)
            if (rq[i].cyc > a) rq.delete(i);
        for (int i = wq.size() - 1; i >= 0; i--)
            if (wq[i].cyc > a) wq.delete(i);
        for (int i = dq.size() - 1; i >= 0; i--)
            if (dq[i] > a) dq.delete(i);
        for (int i = dq5.size() - 1; i >= 0; i--)
            if (dq5[i] > a) dq5.delete(i);
    endfunction

    always @(negedge clk) begin : mon
        rd_e e;
        wr_e w;
        int  x;
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            void'(rq.pop_front());
            fail("rd_missing");
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            e = rq.pop_front();
            chk("rd", int'(bus.oADDR_RD), e.rd);
            chk("rd_alt", int'(bus.oADDR_RD_ALT), e.alt);
            chk("sector", int'(bus.oSECTOR), e.sec);
            chk("second", int'(bus.o2ND_PART_SUBSEC), e.sec2);
            chk("coef", int'(bus.oADDR_COEF), e.coef);
            chk("stage", int'(bus.oSTAGE), e.s);
            chk("st_zero", int'(bus.oST_ZERO), (e.s == 0) ? 1 : 0);
            chk("st_last", int'(bus.oST_LAST),
                (e.s == e.l - 1) ? 1 : 0);
            chk("source", int'(bus.oSOURCE_DATA), e.s % 2);
            chk("busy_run", int'(bus.oBUSY), 1);
        end else begin
            chk("rd_idle", int'(bus.oADDR_RD), 0);
            chk("rd_alt_idle", int'(bus.oADDR_RD_ALT), 0);
        end

        chk("we_excl", int'(bus.oWE_A & bus.oWE_B), 0);
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            void'(wq.pop_front());
            fail("we_missing");
        end
        if (bus.oWE_A || bus.oWE_B) begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                w = wq.pop_front();
                chk("wr", int'(bus.oADDR_WR), w.wr);
                chk("wr_alt", int'(bus.oADDR_WR_ALT), w.alt);
                chk("we_a", int'(bus.oWE_A), w.we_a);
            end else begin
                fail("we_unexpected");
            end
        end

        while (dq.size() > 0 && dq[0] < cyc) begin
            void'(dq.pop_front());
            fail("done_missing");
        end
        if (bus.oDONE) begin
            if (dq.size() > 0) chk("done_cyc", cyc, dq.pop_front());
            else fail("done_unexpected");
        end
        while (dq5.size() > 0 && dq5[0] < cyc) begin
            void'(dq5.pop_front());
            fail("done5_missing");
        end
        if (bus5.oDONE) begin
            if (dq5.size() > 0) chk("done5_cyc", cyc, dq5.pop_front());
            else fail("done5_unexpected");
        end
        while (eq.size() > 0 && eq[0] < cyc) begin
            void'(eq.pop_front());
            fail("err_missing");
        end
        if (bus.oERR) begin
            if (eq.size() > 0) chk("err_cyc", cyc, eq.pop_front());
            else fail("err_unexpected");
        end

        if (cyc == clr5) begin
            h_rd = {0, 0, 0, 0, 0};
            h_ra = {0, 0, 0, 0, 0};
        end
        if (h_rd.size() == P1) begin
            x = h_rd.pop_front();
            chk("wr5_lat", int'(bus5.oADDR_WR), x);
            x = h_ra.pop_front();
            chk("wr5_alt_lat", int'(bus5.oADDR_WR_ALT), x);
        end
        h_rd.push_back(int'(bus5.oADDR_RD));
        h_ra.push_back(int'(bus5.oADDR_RD_ALT));
    end

    task automatic start_xfer(input int l, output int k);
        bit ok;
        @(negedge clk);
        k = cyc;
        ok = (l >= 4 && l <= N_LOG2);
        bus.iLOG2_LEN = 4'(l);
        bus.iSTART = 1'b1;
        if (ok) push_xfer(k, l);
        else eq.push_back(k + 1);
        @(negedge clk);
        bus.iSTART = 1'b0;
        chk("busy_after_start", int'(bus.oBUSY), ok ? 1 : 0);
    endtask

    task automatic abort_at(input int a, input bit use_rst,
                            input int es, input int et);
        while (cyc < a) @(negedge clk);
        if (es >= 0) begin
            chk("abort_stage", int'(bus.oSTAGE), es);
            chk("abort_t", int'(bus.oADDR_RD), et);
        end
        if (use_rst) rst_n = 1'b0;
        else bus.iABORT = 1'b1;
        purge(a);
        clr5 = a + 1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.iABORT = 1'b0;
        chk("abort_busy", int'(bus.oBUSY | bus5.oBUSY), 0);
        chk("abort_we", int'(bus.oWE_A | bus.oWE_B), 0);
        chk("abort_stage0", int'(bus.oSTAGE), 0);
        chk("abort_done", int'(bus.oDONE | bus5.oDONE), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() + wq.size() + dq.size() + dq5.size() +
                eq.size()) > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            fail("timeout");
            rq.delete(); wq.delete(); dq.delete();
            dq5.delete(); eq.delete();
        end
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(bus.oBUSY | bus5.oBUSY), 0);
        chk("idle_stage", int'(bus.oSTAGE), 0);
        chk("idle_source", int'(bus.oSOURCE_DATA), 0);
        chk("idle_flags", int'({bus.oST_ZERO, bus.oST_LAST}), 0);
    endtask

    task automatic do_run(input int l, input int off,
                          input bit use_rst, input bit poke);
        int k;
        start_xfer(l, k);
        if (poke) begin
            @(negedge clk);
            bus.iSTART = 1'b1;
            bus.iLOG2_LEN = 4'($urandom_range(4, 10));
            @(negedge clk);
            bus.iSTART = 1'b0;
        end
        if (off > 0) abort_at(k + off, use_rst, -1, 0);
        wait_idle();
    endtask

    initial begin
        int k, l, tot, off;
        bus.iSTART = 1'b0;
        bus.iABORT = 1'b0;
        bus.iLOG2_LEN = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.oBUSY), 0);
        chk("rst_we", int'(bus.oWE_A | bus.oWE_B), 0);
        chk("rst_flags", int'({bus.oDONE, bus.oERR, bus.oST_ZERO,
            bus.oST_LAST, bus.oSOURCE_DATA, bus.o2ND_PART_SUBSEC}), 0);
        chk("rst_addr", int'(bus.oADDR_WR | bus.oADDR_WR_ALT |
            bus.oADDR_COEF | bus.oSECTOR), 0);
        chk("rst_stage", int'(bus.oSTAGE), 0);
        rst_n = 1'b1;

        do_run(10, 0, 1'b0, 1'b1);
        do_run(4, 0, 1'b0, 1'b0);
        do_run(11, 0, 1'b0, 1'b0);

        start_xfer(10, k);
        abort_at(k + 1 + 3 * 259 + 50, 1'b0, 3, 50);
        wait_idle();
        do_run(10, 0, 1'b0, 1'b0);

        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iABORT = 1'b1;
        bus.iLOG2_LEN = 4'd8;
        @(negedge clk);
        bus.iSTART = 1'b0;
        bus.iABORT = 1'b0;
        chk("start_abort_busy", int'(bus.oBUSY), 0);
        chk("start_abort_err", int'(bus.oERR), 0);

        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(4, 9);
            tot = l * ((1 << (l - 2)) + P0 + 1);
            off = ($urandom_range(0, 2) == 0) ?
                  $urandom_range(4, tot - 1) : 0;
            do_run(l, off, 1'b0, ($urandom_range(0, 1) == 1));
            off = $urandom_range(0, 8);
            do_run((off < 4) ? off : off + 7, 0, 1'b0, 1'b0);
        end

        do_run(9, 300, 1'b1, 1'b0);
        do_run(6, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
